// File: rtl/tinyalu_pkg.sv
// Shared opcode encodings, FSM state type and the single-cycle ALU function
// used by the TinyALU responder.
package tinyalu_pkg;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY     = 2'd1,
        ST_DONE     = 2'd2,
        ST_WAIT_LOW = 2'd3
    } tinyalu_state_t;

    function automatic logic is_fast_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR);
    endfunction

    // Add keeps its carry in bit 8; the logic ops are zero-extended.
    function automatic logic [15:0] fast_result(input logic [7:0] a, input logic [7:0] b,
                                                input logic [2:0] op);
        case (op)
            OP_ADD:  return {7'b0, {1'b0, a} + {1'b0, b}};
            OP_AND:  return {8'h00, a & b};
            OP_XOR:  return {8'h00, a ^ b};
            default: return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/tinyalu_mul_pipe.sv
// Registered 8x8 unsigned multiplier with a matching valid shift register. The core's
// result register is the final stage, so LATENCY-1 stages live here.
module tinyalu_mul_pipe #(
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_in,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        valid_out,
    output logic [15:0] product
);

    if (LATENCY == 1) begin : g_comb
        assign valid_out = valid_in;
        assign product   = {8'h00, a} * {8'h00, b};
    end else begin : g_pipe
        localparam int STAGES = LATENCY - 1;

        logic [STAGES-1:0] valid_q, valid_d;
        logic [15:0]       prod_q [STAGES];
        logic [15:0]       prod_d [STAGES];

        always_comb begin
            valid_d[0] = valid_in;
            prod_d[0]  = {8'h00, a} * {8'h00, b};
            for (int i = 1; i < STAGES; i++) begin
                valid_d[i] = valid_q[i-1];
                prod_d[i]  = prod_q[i-1];
            end
        end

        // NOTE: data stages are reset along with valid so a reset leaves no stale product in the pipe.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                valid_q <= '0;
                for (int i = 0; i < STAGES; i++) prod_q[i] <= 16'h0000;
            end else begin
                valid_q <= valid_d;
                for (int i = 0; i < STAGES; i++) prod_q[i] <= prod_d[i];
            end
        end

        assign valid_out = valid_q[STAGES-1];
        assign product   = prod_q[STAGES-1];
    end

endmodule

// File: rtl/tinyalu_core.sv
// TinyALU responder: captures a command on start, returns the result with a one-cycle done
// pulse and waits for start to fall before accepting another command.
module tinyalu_core
    import tinyalu_pkg::*;
#(
    parameter int MUL_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [2:0]  op,
    input  logic        start,
    output logic        done,
    output logic [15:0] result,
    output logic        illegal_op
);

    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    tinyalu_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      result_q, result_d;
    logic             done_q, done_d;
    logic             illegal_q, illegal_d;
    logic             mul_start, mul_valid;
    logic [15:0]      mul_product;

    tinyalu_mul_pipe #(.LATENCY(MUL_LATENCY)) u_mul_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid_in  (mul_start),
        .a         (A),
        .b         (B),
        .valid_out (mul_valid),
        .product   (mul_product)
    );

    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        illegal_d = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_fast_op(op)) begin
                        state_d  = ST_DONE;
                        result_d = fast_result(A, B, op);
                    end else if (op == OP_MUL) begin
                        mul_start = 1'b1;
                        if (MUL_LATENCY == 1) begin
                            state_d  = ST_DONE;
                            result_d = mul_product;
                        end else begin
                            state_d = ST_BUSY;
                            cnt_d   = CNT_W'(MUL_LATENCY - 1);
                        end
                    end else if (op != OP_NOP) begin
                        illegal_d = 1'b1;
                        state_d   = ST_WAIT_LOW;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (mul_valid) begin
                    state_d  = ST_DONE;
                    result_d = mul_product;
                end
            end
            ST_DONE:     state_d = start ? ST_WAIT_LOW : ST_IDLE;
            ST_WAIT_LOW: if (!start) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        done_d = (state_d == ST_DONE);
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            result_q  <= 16'h0000;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    // The pipe's valid must arrive exactly when the down-counter expires.
    a_mul_sync: assert property (@(posedge clk) disable iff (!reset_n)
        (state_q == ST_BUSY) |-> (mul_valid == (cnt_q == CNT_W'(1))));

    assign done       = done_q;
    assign result     = result_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_tinyalu_core.sv
// Directed bench for tinyalu_core: three instances (MUL_LATENCY 3, 1, 5) share the
// initiator signals; each scenario task checks done timing, pulse counts and results.
module tb_tinyalu_core;
    import tinyalu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  a_in, b_in;
    logic [2:0]  op_in;
    logic        start;
    logic        done_w   [3];
    logic [15:0] result_w [3];
    logic        ill_w    [3];

    int passed = 0;
    int total  = 0;
    int first_s [3];
    int cnt_s   [3];
    int ill_s   [3];
    logic [15:0] res_s [3];
    int lat_exp [3] = '{3, 1, 5};

    always #5 clk = ~clk;

    tinyalu_core #(.MUL_LATENCY(3)) u_l3 (
        .clk(clk), .reset_n(reset_n), .A(a_in), .B(b_in), .op(op_in), .start(start),
        .done(done_w[0]), .result(result_w[0]), .illegal_op(ill_w[0]));
    tinyalu_core #(.MUL_LATENCY(1)) u_l1 (
        .clk(clk), .reset_n(reset_n), .A(a_in), .B(b_in), .op(op_in), .start(start),
        .done(done_w[1]), .result(result_w[1]), .illegal_op(ill_w[1]));
    tinyalu_core #(.MUL_LATENCY(5)) u_l5 (
        .clk(clk), .reset_n(reset_n), .A(a_in), .B(b_in), .op(op_in), .start(start),
        .done(done_w[2]), .result(result_w[2]), .illegal_op(ill_w[2]));

    // Drive one command, hold start for `hold` cycles, observe `window` cycles.
    // Cycle k=1 is the capture edge; operands are scrambled right after it.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                         input int hold, input int window);
        a_in  = a;
        b_in  = b;
        op_in = o;
        start = 1'b1;
        for (int d = 0; d < 3; d++) begin
            first_s[d] = -1;
            cnt_s[d]   = 0;
            ill_s[d]   = 0;
            res_s[d]   = 16'hxxxx;
        end
        for (int k = 1; k <= window; k++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (done_w[d] === 1'b1) begin
                    cnt_s[d]++;
                    if (first_s[d] < 0) first_s[d] = k;
                    res_s[d] = result_w[d];
                end
                if (ill_w[d] === 1'b1) ill_s[d]++;
            end
            if (k == 1) begin
                a_in = 8'h00;
                b_in = 8'h00;
            end
            if (k >= hold) start = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        a_in    = 8'h00;
        b_in    = 8'h00;
        op_in   = OP_NOP;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            total++;
            if (done_w[d] !== 1'b0 || ill_w[d] !== 1'b0 || result_w[d] !== 16'h0000)
                $display("FAIL reset_outputs dut%0d: done=%b ill=%b result=%h, expected 0 0 0000",
                         d, done_w[d], ill_w[d], result_w[d]);
            else passed++;
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        issue(8'hFF, 8'hFF, OP_ADD, 1, 4);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (first_s[d] !== 1 || cnt_s[d] !== 1)
                $display("FAIL add_timing dut%0d: first=%0d count=%0d, expected 1 1", d, first_s[d], cnt_s[d]);
            else passed++;
            total++;
            if (res_s[d] !== 16'h01FE)
                $display("FAIL add_result dut%0d: got %h expected 01fe", d, res_s[d]);
            else passed++;
        end
    endtask

    task automatic test_logic();
        issue(8'hF0, 8'h3C, OP_AND, 1, 3);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (cnt_s[d] !== 1 || res_s[d] !== 16'h0030)
                $display("FAIL and_op dut%0d: count=%0d result=%h, expected 1 0030", d, cnt_s[d], res_s[d]);
            else passed++;
        end
        issue(8'hF0, 8'h3C, OP_XOR, 1, 3);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (cnt_s[d] !== 1 || res_s[d] !== 16'h00CC)
                $display("FAIL xor_op dut%0d: count=%0d result=%h, expected 1 00cc", d, cnt_s[d], res_s[d]);
            else passed++;
        end
    endtask

    task automatic test_mul();
        issue(8'hFF, 8'hFF, OP_MUL, 5, 8);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (first_s[d] !== lat_exp[d] || cnt_s[d] !== 1)
                $display("FAIL mul_timing dut%0d: first=%0d count=%0d, expected %0d 1",
                         d, first_s[d], cnt_s[d], lat_exp[d]);
            else passed++;
            total++;
            if (res_s[d] !== 16'hFE01)
                $display("FAIL mul_result dut%0d: got %h expected fe01", d, res_s[d]);
            else passed++;
        end
        issue(8'h0C, 8'h0B, OP_MUL, 5, 7);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (cnt_s[d] !== 1 || res_s[d] !== 16'h0084)
                $display("FAIL mul_small dut%0d: count=%0d result=%h, expected 1 0084", d, cnt_s[d], res_s[d]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_mul();
        int dones [3];
        a_in  = 8'h07;
        b_in  = 8'h09;
        op_in = OP_MUL;
        start = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        start   = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            total++;
            if (done_w[d] !== 1'b0 || result_w[d] !== 16'h0000)
                $display("FAIL mid_reset_clear dut%0d: done=%b result=%h, expected 0 0000",
                         d, done_w[d], result_w[d]);
            else passed++;
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int d = 0; d < 3; d++) dones[d] = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) if (done_w[d] === 1'b1) dones[d]++;
        end
        for (int d = 0; d < 3; d++) begin
            total++;
            if (dones[d] !== 0 || result_w[d] !== 16'h0000)
                $display("FAIL mid_reset_discard dut%0d: dones=%0d result=%h, expected 0 0000",
                         d, dones[d], result_w[d]);
            else passed++;
        end
        issue(8'h02, 8'h03, OP_ADD, 1, 3);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (first_s[d] !== 1 || res_s[d] !== 16'h0005)
                $display("FAIL add_after_reset dut%0d: first=%0d result=%h, expected 1 0005",
                         d, first_s[d], res_s[d]);
            else passed++;
        end
    endtask

    task automatic test_held_start_and_noop();
        issue(8'h01, 8'h01, OP_ADD, 7, 9);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (cnt_s[d] !== 1 || res_s[d] !== 16'h0002)
                $display("FAIL held_start dut%0d: count=%0d result=%h, expected 1 0002", d, cnt_s[d], res_s[d]);
            else passed++;
        end
        issue(8'h55, 8'h66, OP_NOP, 1, 4);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (cnt_s[d] !== 0 || ill_s[d] !== 0 || result_w[d] !== 16'h0002)
                $display("FAIL no_op dut%0d: dones=%0d ills=%0d result=%h, expected 0 0 0002",
                         d, cnt_s[d], ill_s[d], result_w[d]);
            else passed++;
        end
    endtask

    task automatic test_illegal();
        issue(8'h12, 8'h34, 3'b101, 1, 4);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (ill_s[d] !== 1 || cnt_s[d] !== 0)
                $display("FAIL illegal_pulse dut%0d: ills=%0d dones=%0d, expected 1 0", d, ill_s[d], cnt_s[d]);
            else passed++;
            total++;
            if (result_w[d] !== 16'h0002)
                $display("FAIL illegal_keeps_result dut%0d: got %h expected 0002", d, result_w[d]);
            else passed++;
        end
        issue(8'h12, 8'h34, 3'b111, 6, 8);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (ill_s[d] !== 1 || cnt_s[d] !== 0)
                $display("FAIL illegal_held dut%0d: ills=%0d dones=%0d, expected 1 0", d, ill_s[d], cnt_s[d]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_logic();
        test_mul();
        test_reset_mid_mul();
        test_held_start_and_noop();
        test_illegal();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
